// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit words, each either a writable control reg or a sticky clear-on-read status reg.
// Define AXIL_REG_BANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_bank #(
    parameter int                         ADDR_WIDTH  = 8,
    parameter int                         NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]        STATUS_MASK = '0,
    parameter logic [NUM_REGS*32-1:0]     CTRL_RESET  = '0
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,

    output logic [NUM_REGS*32-1:0]   ctrl_q,
    output logic [NUM_REGS-1:0]      ctrl_wr_pulse,
    input  logic [NUM_REGS*32-1:0]   status_set,
    output logic [NUM_REGS-1:0]      rd_pulse
);
    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_BANK_SLVERR_EN
    localparam logic [1:0] RESP_BAD  = 2'b10;
`else
    localparam logic [1:0] RESP_BAD  = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_WAIT_AW, W_WAIT_W, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA} rd_state_t;

    // One-hot register select; an out-of-range index yields all zeros.
    function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++)
            sel[i] = (idx == IDX_W'(i));
        return sel;
    endfunction

    logic [31:0]         regs [NUM_REGS];
    logic                addr_lsb_unused;

    // Write channel
    wr_state_t           wr_state, wr_next;
    logic                wr_first;
    logic                aw_ready_int, w_ready_int, aw_hs, w_hs;
    logic [IDX_W-1:0]    aw_idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic [NUM_REGS-1:0] wr_sel, wr_apply;

    // Read channel
    rd_state_t           rd_state, rd_next;
    logic                rd_first, ar_hs;
    logic [NUM_REGS-1:0] ar_sel, rd_sel_q;
    logic [31:0]         ar_data, rdata_q;
    logic [1:0]          rresp_q;

    assign addr_lsb_unused = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], status_set};

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_next      = wr_state;
        aw_ready_int = 1'b0;
        w_ready_int  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                aw_ready_int = 1'b1;
                w_ready_int  = 1'b1;
                if (s_axil_awvalid && s_axil_wvalid) wr_next = W_RESP;
                else if (s_axil_wvalid)              wr_next = W_WAIT_AW;
                else if (s_axil_awvalid)             wr_next = W_WAIT_W;
            end
            W_WAIT_AW: begin
                aw_ready_int = 1'b1;
                if (s_axil_awvalid) wr_next = W_RESP;
            end
            W_WAIT_W: begin
                w_ready_int = 1'b1;
                if (s_axil_wvalid) wr_next = W_RESP;
            end
            W_RESP: begin
                if (s_axil_bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    assign s_axil_awready = aw_ready_int & ~reset;
    assign s_axil_wready  = w_ready_int & ~reset;
    assign aw_hs          = s_axil_awvalid & s_axil_awready;
    assign w_hs           = s_axil_wvalid & s_axil_wready;
    assign s_axil_bvalid  = (wr_state == W_RESP) & ~reset;
    assign wr_sel         = decode(aw_idx_q);
    assign s_axil_bresp   = (s_axil_bvalid && !(|wr_sel)) ? RESP_BAD : RESP_OKAY;
    assign wr_apply       = wr_first ? (wr_sel & ~STATUS_MASK) : '0;
    assign ctrl_wr_pulse  = reset ? '0 : wr_apply;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= W_IDLE;
            wr_first <= 1'b0;
        end else begin
            wr_state <= wr_next;
            wr_first <= (wr_state != W_RESP) && (wr_next == W_RESP);
        end
    end

    // NOTE: captured address/data are pure datapath qualified by the FSM, so they carry no reset.
    always_ff @(posedge clk) begin
        if (aw_hs) aw_idx_q <= s_axil_awaddr[ADDR_WIDTH-1:2];
        if (w_hs) begin
            wdata_q <= s_axil_wdata;
            wstrb_q <= s_axil_wstrb;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (s_axil_arvalid) rd_next = R_DATA;
            R_DATA:  if (s_axil_rready)  rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    assign s_axil_arready = (rd_state == R_IDLE) & ~reset;
    assign ar_hs          = s_axil_arvalid & s_axil_arready;
    assign ar_sel         = decode(s_axil_araddr[ADDR_WIDTH-1:2]);

    always_comb begin
        ar_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ar_sel[i]) ar_data = ar_data | regs[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_first <= 1'b0;
            rd_sel_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            rd_first <= ar_hs;
            if (ar_hs) begin
                rd_sel_q <= ar_sel;
                rdata_q  <= ar_data;
                rresp_q  <= (|ar_sel) ? RESP_OKAY : RESP_BAD;
            end
        end
    end

    assign s_axil_rvalid = (rd_state == R_DATA) & ~reset;
    assign s_axil_rdata  = reset ? '0 : rdata_q;
    assign s_axil_rresp  = reset ? RESP_OKAY : rresp_q;
    assign rd_pulse      = (rd_first && !reset) ? rd_sel_q : '0;

    // NOTE: the bank is flop-based, so it is reset like any other state to give defined control values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= STATUS_MASK[i] ? 32'h0 : CTRL_RESET[32*i +: 32];
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (STATUS_MASK[i]) begin
                    // A read clears what it returned; bits being set this cycle win.
                    regs[i] <= (regs[i] & ~((ar_hs && ar_sel[i]) ? regs[i] : 32'h0))
                               | status_set[32*i +: 32];
                end else if (wr_apply[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        ctrl_q = '0;
        for (int i = 0; i < NUM_REGS; i++)
            ctrl_q[32*i +: 32] = STATUS_MASK[i] ? 32'h0 : regs[i];
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Self-checking bench for axil_reg_bank: transaction tasks drive directed vectors, a spec-level model predicts results.
`timescale 1ns/1ps
module tb_axil_reg_bank;
    localparam int                     ADDR_WIDTH  = 8;
    localparam int                     NUM_REGS    = 16;
    localparam logic [NUM_REGS-1:0]    STATUS_MASK = 16'h0004;
    localparam logic [NUM_REGS*32-1:0] CTRL_RESET  = (512'hCAFEF00D << 160) | 512'h12345678;
`ifdef AXIL_REG_BANK_SLVERR_EN
    localparam logic [1:0] BAD_RESP = 2'b10;
`else
    localparam logic [1:0] BAD_RESP = 2'b00;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [ADDR_WIDTH-1:0]    awaddr = '0, araddr = '0;
    logic                     awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]              wdata = '0;
    logic [3:0]               wstrb = '0;
    logic                     awready, wready, bvalid, arready, rvalid;
    logic [1:0]               bresp, rresp;
    logic [31:0]              rdata;
    logic [NUM_REGS*32-1:0]   ctrl_q;
    logic [NUM_REGS*32-1:0]   status_set = '0;
    logic [NUM_REGS-1:0]      ctrl_wr_pulse, rd_pulse;

    axil_reg_bank #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS),
        .STATUS_MASK(STATUS_MASK), .CTRL_RESET(CTRL_RESET)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .ctrl_q(ctrl_q), .ctrl_wr_pulse(ctrl_wr_pulse), .status_set(status_set), .rd_pulse(rd_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Model: control contents, accumulated status bits, and which pulses are due this cycle.
    logic [31:0]         model_ctrl   [NUM_REGS];
    logic [31:0]         model_sticky [NUM_REGS];
    logic [NUM_REGS-1:0] clear_pending = '0;
    logic [NUM_REGS-1:0] exp_wr_pulse = '0;
    logic [NUM_REGS-1:0] exp_rd_pulse = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Status bits accumulate every edge; a read replaces them with only what is being set that cycle.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset)                 model_sticky[i] <= 32'h0;
            else if (clear_pending[i]) model_sticky[i] <= status_set[32*i +: 32];
            else                       model_sticky[i] <= model_sticky[i] | status_set[32*i +: 32];
        end
        clear_pending <= '0;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            if (!reset)
                for (int i = 0; i < NUM_REGS; i++)
                    check($sformatf("ctrl_q[%0d]", i), ctrl_q[32*i +: 32],
                          STATUS_MASK[i] ? 32'h0 : model_ctrl[i]);
            check("ctrl_wr_pulse", 32'(ctrl_wr_pulse), 32'(exp_wr_pulse));
            check("rd_pulse", 32'(rd_pulse), 32'(exp_rd_pulse));
        end
    end

    // All transaction tasks start and end 1 ns after a rising edge.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        exp_wr_pulse = '0; exp_rd_pulse = '0;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_awready", 32'(awready), 32'd0);
            check("rst_wready",  32'(wready),  32'd0);
            check("rst_arready", 32'(arready), 32'd0);
            check("rst_bvalid",  32'(bvalid),  32'd0);
            check("rst_rvalid",  32'(rvalid),  32'd0);
            check("rst_bresp",   32'(bresp),   32'd0);
            check("rst_rresp",   32'(rresp),   32'd0);
            check("rst_rdata",   rdata,        32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model_ctrl[i] = CTRL_RESET[32*i +: 32];
        @(negedge clk);
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_wready",  32'(wready),  32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_bvalid",  32'(bvalid),  32'd0);
        @(posedge clk); #1;
    endtask

    task automatic axil_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int aw_lag, input int w_lag, input int b_lag);
        int idx, cyc;
        bit in_rng, is_ctrl, aw_done, w_done, aw_now, w_now, done, first;
        logic [1:0] exp_resp;
        idx     = int'(addr[7:2]);
        in_rng  = idx < NUM_REGS;
        is_ctrl = 1'b0;
        if (in_rng) is_ctrl = !STATUS_MASK[idx];
        exp_resp = in_rng ? 2'b00 : BAD_RESP;
        awaddr = addr; wdata = data; wstrb = strb;
        cyc = 0; aw_done = 1'b0; w_done = 1'b0;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && (cyc >= aw_lag);
            wvalid  = !w_done && (cyc >= w_lag);
            @(negedge clk);
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge clk); #1;
            aw_done = aw_done | aw_now;
            w_done  = w_done | w_now;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_handshake_done", 32'({aw_done, w_done}), 32'd3);
        if (is_ctrl) exp_wr_pulse[idx] = 1'b1;
        cyc = 0; first = 1'b1; done = 1'b0;
        while (!done && cyc < 50) begin
            bready = (cyc >= b_lag);
            @(negedge clk);
            check("bvalid", 32'(bvalid), 32'd1);
            check("bresp", 32'(bresp), 32'(exp_resp));
            check("awready_in_resp", 32'(awready), 32'd0);
            check("wready_in_resp", 32'(wready), 32'd0);
            done = bready;
            @(posedge clk); #1;
            if (first) begin
                exp_wr_pulse = '0;
                if (is_ctrl)
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) model_ctrl[idx][8*b +: 8] = data[8*b +: 8];
                first = 1'b0;
            end
            cyc++;
        end
        bready = 1'b0;
        check("b_handshake_done", 32'(done), 32'd1);
    endtask

    task automatic axil_read(input logic [7:0] addr, input int r_lag,
                             input logic [NUM_REGS*32-1:0] set_in_ar, output logic [31:0] got);
        int idx, cyc;
        bit in_rng, hs, done;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        idx      = int'(addr[7:2]);
        in_rng   = idx < NUM_REGS;
        exp_resp = in_rng ? 2'b00 : BAD_RESP;
        exp_data = 32'h0;
        araddr = addr; arvalid = 1'b1; status_set = set_in_ar;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = arready;
            if (hs && in_rng) begin
                if (STATUS_MASK[idx]) begin
                    exp_data = model_sticky[idx];
                    clear_pending[idx] = 1'b1;
                end else begin
                    exp_data = model_ctrl[idx];
                end
            end
            @(posedge clk); #1;
            status_set = '0;
            cyc++;
        end
        arvalid = 1'b0;
        check("ar_handshake_done", 32'(hs), 32'd1);
        if (hs && in_rng) exp_rd_pulse[idx] = 1'b1;
        cyc = 0; done = 1'b0; got = 32'h0;
        while (!done && cyc < 50) begin
            rready = (cyc >= r_lag);
            @(negedge clk);
            check("rvalid", 32'(rvalid), 32'd1);
            check("rdata", rdata, exp_data);
            check("rresp", 32'(rresp), 32'(exp_resp));
            check("arready_in_data", 32'(arready), 32'd0);
            got  = rdata;
            done = rready;
            @(posedge clk); #1;
            exp_rd_pulse = '0;
            cyc++;
        end
        rready = 1'b0;
        check("r_handshake_done", 32'(done), 32'd1);
    endtask

    task automatic pulse_status(input int idx, input logic [31:0] val);
        status_set = '0;
        status_set[32*idx +: 32] = val;
        @(posedge clk); #1;
        status_set = '0;
    endtask

    initial begin
        logic [31:0] got;
        logic [NUM_REGS*32-1:0] set_vec;
        for (int i = 0; i < NUM_REGS; i++) begin
            model_ctrl[i]   = 32'h0;
            model_sticky[i] = 32'h0;
        end
        @(posedge clk); #1;
        cmp_en = 1'b1;
        do_reset(2);

        axil_read(8'h00, 0, '0, got);
        check("lit_reg0_reset", got, 32'h12345678);

        // Data three cycles ahead of address, response stalled two cycles.
        axil_write(8'h04, 32'hAABBCCDD, 4'b0101, 3, 0, 2);
        axil_read(8'h04, 1, '0, got);
        check("lit_reg1_strobed", got, 32'h00BB00DD);

        // Address ahead of data; zero strobes still pulse but change nothing.
        axil_write(8'h14, 32'hFFFFFFFF, 4'b0000, 0, 2, 0);
        axil_read(8'h14, 0, '0, got);
        check("lit_reg5_nostrb", got, 32'hCAFEF00D);

        pulse_status(2, 32'h00000011);
        axil_read(8'h08, 0, '0, got);
        check("lit_status_first", got, 32'h00000011);
        axil_read(8'h08, 0, '0, got);
        check("lit_status_cleared", got, 32'h0);
        set_vec = '0;
        set_vec[64 +: 32] = 32'h00000010;
        axil_read(8'h08, 0, set_vec, got);
        check("lit_status_set_in_ar", got, 32'h0);
        axil_read(8'h08, 2, '0, got);
        check("lit_status_survived", got, 32'h00000010);

        axil_write(8'h08, 32'hFFFFFFFF, 4'b1111, 0, 0, 0);
        axil_read(8'h08, 0, '0, got);
        check("lit_status_wr_ignored", got, 32'h0);

        axil_read(8'h40, 0, '0, got);
        check("lit_oor_rdata", got, 32'h0);
        axil_write(8'h40, 32'h87654321, 4'b1111, 1, 0, 1);
        axil_write(8'hFC, 32'h87654321, 4'b1111, 0, 0, 0);

        // Same-cycle read and write of reg 0 returns the old value.
        fork
            axil_write(8'h00, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
            axil_read(8'h00, 0, '0, got);
        join
        check("lit_rd_wr_same_cycle", got, 32'h12345678);
        axil_read(8'h00, 0, '0, got);
        check("lit_reg0_written", got, 32'hDEADBEEF);

        // Read accepted during the first response cycle still sees pre-write data.
        fork
            axil_write(8'h0C, 32'h000000A5, 4'b0001, 0, 0, 1);
            begin
                @(posedge clk); #1;
                axil_read(8'h0C, 0, '0, got);
            end
        join
        check("lit_rd_during_resp", got, 32'h0);
        axil_read(8'h0C, 0, '0, got);
        check("lit_reg3_written", got, 32'h000000A5);

        // Reset lands while a response is pending with bready low.
        awaddr = 8'h0C; wdata = 32'h00000055; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        check("rst_resp_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        exp_wr_pulse[3] = 1'b1;
        @(negedge clk);
        check("rst_resp_bvalid", 32'(bvalid), 32'd1);
        @(posedge clk); #1;
        exp_wr_pulse = '0;
        model_ctrl[3] = 32'h00000055;
        do_reset(1);
        repeat (3) @(posedge clk);
        #1;
        axil_read(8'h00, 0, '0, got);
        check("lit_reg0_after_reset", got, 32'h12345678);
        axil_read(8'h0C, 0, '0, got);
        check("lit_reg3_after_reset", got, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 Parameter ADDR_WIDTH, 8, byte-address width; SHALL satisfy NUM_REGS <= 2^(ADDR_WIDTH-2).
REQ-002 Parameter NUM_REGS, 16, number of 32-bit word registers; index = addr[ADDR_WIDTH-1:2].
REQ-003 Parameter STATUS_MASK, NUM_REGS bits, 0; bit i=1 makes reg i a sticky clear-on-read status reg, bit i=0 makes it a software-writable control reg.
REQ-004 Parameter CTRL_RESET, NUM_REGS*32 bits, 0; reset value of each control reg, reg i at bits [32i+31:32i].
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 s_axil_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  AXI4-Lite write address channel.
REQ-008 s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-009 s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-010 s_axil_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
REQ-011 s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-012 ctrl_q  out  NUM_REGS*32  current control reg values; status-slot bits SHALL read 0.
REQ-013 ctrl_wr_pulse  out  NUM_REGS  one-cycle pulse per applied control write.
REQ-014 status_set  in  NUM_REGS*32  per-bit set inputs for status regs; ignored for control slots.
REQ-015 rd_pulse  out  NUM_REGS  one-cycle pulse per completed read of reg i.

Function
REQ-016 Write FSM states SHALL be IDLE (awready=wready=1), WAIT_AW (awready=1), WAIT_W (wready=1), RESP (bvalid=1); awready/wready SHALL be 0 in RESP.
REQ-017 IDLE transitions: aw+w both valid -> RESP; only w -> WAIT_AW; only aw -> WAIT_W; WAIT_* -> RESP on missing valid; RESP -> IDLE when bready sampled high.
REQ-018 Address and data SHALL be captured in the cycle their handshake completes; write SHALL be applied at the edge ending the first RESP cycle (new value visible on ctrl_q two cycles after final handshake).
REQ-019 Control writes SHALL update only byte lanes with wstrb=1; ctrl_wr_pulse[i] SHALL assert in that first RESP cycle, even when wstrb=0.
REQ-020 Writes to status regs SHALL be discarded with bresp OKAY and no pulse.
REQ-021 Read FSM states SHALL be IDLE (arready=1) and DATA (rvalid=1); IDLE -> DATA on arvalid, DATA -> IDLE on rready.
REQ-022 rdata SHALL be registered at the ar handshake edge and held stable until the rready handshake.
REQ-023 Status reg i SHALL update every cycle as sticky <= sticky | status_set[i].
REQ-024 Reading status reg i SHALL clear, at the ar handshake edge, exactly the bits returned in rdata, except bits whose status_set is high that cycle, which SHALL stay set.
REQ-025 rd_pulse[i] SHALL assert for one cycle in the first DATA cycle.
REQ-026 Simultaneous read and write of the same control reg: read SHALL return the pre-write value.
REQ-027 Read and write FSMs SHALL operate independently and concurrently.

Reset
REQ-028 While reset is high, all readies, bvalid, rvalid, ctrl_wr_pulse and rd_pulse SHALL be 0; bresp, rresp and rdata SHALL be 0.
REQ-029 Reset SHALL load ctrl regs from CTRL_RESET, clear sticky status, and put both FSMs in IDLE, abandoning any in-flight transaction without a response; readies SHALL be 1 the first cycle after reset deasserts.

Configuration
REQ-030 With macro AXIL_REG_BANK_SLVERR_EN defined, accesses with index >= NUM_REGS SHALL return bresp/rresp 2'b10 (SLVERR), rdata 0, no state change, no pulse.
REQ-031 Without AXIL_REG_BANK_SLVERR_EN, such accesses SHALL return OKAY with rdata 0, no state change, no pulse.

Verification
REQ-032 Reset, then read reg 0 with CTRL_RESET[31:0]=0x12345678 -> rdata 0x12345678, rresp 00.
REQ-033 Write 0xAABBCCDD wstrb 0101 to reg 1 (reset 0) with awvalid 3 cycles after wvalid -> reg 1 = 0x00BB00DD, one ctrl_wr_pulse[1], bvalid held through 2 cycles of bready low.
REQ-034 Pulse status_set[2]=0x0000_0011, read reg 2 -> 0x11; read again -> 0x0; set bit 4 in the read-accept cycle -> next read 0x10.
REQ-035 Read address 0x40 with NUM_REGS=16 -> rresp 10 with macro, 00 without; rdata 0 in both cases.
REQ-036 Assert reset during RESP with bready low -> bvalid 0 next cycle, awready 1 after reset deasserts, no further write pulse.
